// File: rtl/cpu_pkg.sv
// Shared CPU definitions: phase encoding, opcodes, instruction field slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

   // Phase encoding shared with the phase generator (decoder).
   typedef enum logic [1:0] {
      PH_FETCH     = 2'd0,
      PH_DECODE    = 2'd1,
      PH_EXECUTE   = 2'd2,
      PH_WRITEBACK = 2'd3
   } phase_t;

   // Opcodes that change control behaviour; all others are plain ALU ops.
   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_JMP = 4'hE
   } opcode_t;

   // Instruction field slices: [7:4] opcode, [3:2] rd, [1:0] rs.
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;
   localparam int RD_MSB  = 3;
   localparam int RD_LSB  = 2;
   localparam int RS_MSB  = 1;
   localparam int RS_LSB  = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of cycles an instruction read has been waiting for its ack.
// Latency: expired is combinational from the registered count.
// Backpressure: none; it stops counting once LIMIT is reached.
module mem_wait_timer #(
   parameter int LIMIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   assign expired = (count == CW'(LIMIT));

   // Count stalled cycles, saturating at LIMIT; clear wins over increment.
   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         count <= '0;
      end else if (inc && !expired) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/phase_control_unit.sv
// Consumes one-hot phase strobes: fetch handshake, decode, ALU strobe, writeback/PC update.
// Latency: fetch completes on the ack edge (zero stall if acked with the strobe); strobes are combinational.
// Backpressure: hold stalls the phase generator while a fetch waits for mem_ack, until timeout.
module phase_control_unit
   import cpu_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                ADDR_W      = 8,
   parameter logic [ADDR_W-1:0] PC_RESET    = '0,
   parameter int                MEM_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch,
   input  logic              decode,
   input  logic              execute,
   input  logic              writeback,
   output logic              hold,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic [3:0]        opcode,
   output logic [1:0]        rd,
   output logic [1:0]        rs,
   output logic              alu_en,
   output logic              reg_we,
   output logic [ADDR_W-1:0] pc,
   output logic              seq_err,
   output logic              timeout
);

   // Expected-phase states, numbered like the strobe bit positions.
   localparam logic [1:0] EXP_F = 2'd0;
   localparam logic [1:0] EXP_D = 2'd1;
   localparam logic [1:0] EXP_E = 2'd2;
   localparam logic [1:0] EXP_W = 2'd3;

   logic [1:0]        state;
   logic [3:0]        strobes;
   logic [3:0]        exp_strobe;
   logic              any_strobe;
   logic              legal;
   logic              expired;
   logic              wait_clear;
   logic              wait_inc;
   logic [ADDR_W-1:0] pc_inc;

   assign strobes    = {writeback, execute, decode, fetch};
   assign exp_strobe = 4'(4'b0001 << state);
   assign any_strobe = |strobes;
   // Legal only when exactly the expected strobe is high.
   assign legal      = (strobes == exp_strobe);
   assign pc_inc     = pc + ADDR_W'(1);
   assign mem_addr   = pc;

   // Phase-qualified combinational strobes, all forced low during reset.
   always_comb begin
      mem_req = reset && legal && (state == EXP_F);
      hold    = mem_req && !mem_ack && !expired;
      alu_en  = reset && legal && (state == EXP_E) && (opcode != OP_NOP);
      reg_we  = reset && legal && (state == EXP_W) && (opcode != OP_NOP) && (opcode != OP_JMP);
   end

   // The wait count only survives while a request is outstanding and unanswered.
   assign wait_clear = !mem_req || mem_ack || expired;
   assign wait_inc   = mem_req && !mem_ack;

   mem_wait_timer #(
      .LIMIT(MEM_TIMEOUT)
   ) u_wait (
      .clock  (clock),
      .reset  (reset),
      .clear  (wait_clear),
      .inc    (wait_inc),
      .expired(expired)
   );

   // Phase FSM, instruction register, decoded fields, PC and sticky error flags.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= EXP_F;
         pc      <= PC_RESET;
         instr   <= '0;
         opcode  <= '0;
         rd      <= '0;
         rs      <= '0;
         seq_err <= 1'b0;
         timeout <= 1'b0;
      end else if (any_strobe) begin
         if (!legal) begin
            // Bad strobe is dropped; resynchronise on the next fetch.
            seq_err <= 1'b1;
            state   <= EXP_F;
         end else begin
            case (state)
               EXP_F: begin
                  if (mem_ack) begin
                     instr <= mem_rdata;
                     pc    <= pc_inc;
                     state <= EXP_D;
                  end else if (expired) begin
                     // Abandoned fetch executes as a NOP.
                     instr   <= '0;
                     pc      <= pc_inc;
                     timeout <= 1'b1;
                     state   <= EXP_D;
                  end
               end
               EXP_D: begin
                  opcode <= instr[OPC_MSB:OPC_LSB];
                  rd     <= instr[RD_MSB:RD_LSB];
                  rs     <= instr[RS_MSB:RS_LSB];
                  state  <= EXP_E;
               end
               EXP_E: begin
                  state <= EXP_W;
               end
               default: begin
                  if (opcode == OP_JMP) begin
                     pc <= {{(ADDR_W-4){1'b0}}, rd, rs};
                  end
                  state <= EXP_F;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_phase_control_unit.sv
// Directed bench for phase_control_unit with hand-computed expectations.
// Latency: inputs change 1ns after a rising edge; outputs are sampled mid-cycle.
// Backpressure: hold is checked cycle by cycle against the expected stall length.
module tb_phase_control_unit;

   logic       clock;
   logic       reset;
   logic       fetch;
   logic       decode;
   logic       execute;
   logic       writeback;
   logic       hold;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic [7:0] instr;
   logic [3:0] opcode;
   logic [1:0] rd;
   logic [1:0] rs;
   logic       alu_en;
   logic       reg_we;
   logic [7:0] pc;
   logic       seq_err;
   logic       timeout;

   int checks;
   int failures;

   phase_control_unit dut (
      .clock    (clock),
      .reset    (reset),
      .fetch    (fetch),
      .decode   (decode),
      .execute  (execute),
      .writeback(writeback),
      .hold     (hold),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .instr    (instr),
      .opcode   (opcode),
      .rd       (rd),
      .rs       (rs),
      .alu_en   (alu_en),
      .reg_we   (reg_we),
      .pc       (pc),
      .seq_err  (seq_err),
      .timeout  (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Run decode/execute/writeback with expected decoded opcode and strobes.
   task automatic run_dew(input string tag, input logic [3:0] eo, input logic ea, input logic ew);
      decode = 1'b1;
      tick();
      decode = 1'b0;
      check({tag, "_opcode"}, 32'(opcode), 32'(eo));
      execute = 1'b1;
      #1;
      check({tag, "_alu_en"}, 32'(alu_en), 32'(ea));
      tick();
      execute   = 1'b0;
      writeback = 1'b1;
      #1;
      check({tag, "_alu_en_off"}, 32'(alu_en), 32'(0));
      check({tag, "_reg_we"}, 32'(reg_we), 32'(ew));
      tick();
      writeback = 1'b0;
   endtask

   // Unchecked zero-wait instruction cycle, used to walk the PC.
   task automatic quick_cycle(input logic [7:0] data);
      fetch = 1'b1; mem_ack = 1'b1; mem_rdata = data;
      tick();
      fetch = 1'b0; mem_ack = 1'b0;
      decode = 1'b1;  tick(); decode = 1'b0;
      execute = 1'b1; tick(); execute = 1'b0;
      writeback = 1'b1; tick(); writeback = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b0; fetch = 1'b1; decode = 1'b0; execute = 1'b0; writeback = 1'b0;
      mem_ack = 1'b0; mem_rdata = 8'h00;

      // Reset with fetch high
      tick();
      check("rst_mem_req", 32'(mem_req), 32'(0));
      check("rst_hold", 32'(hold), 32'(0));
      check("rst_pc", 32'(pc), 32'(0));
      check("rst_seq_err", 32'(seq_err), 32'(0));
      check("rst_timeout", 32'(timeout), 32'(0));
      check("rst_instr", 32'(instr), 32'(0));

      // Zero-wait fetch of 0x5B
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h5B;
      #1;
      check("zw_mem_req", 32'(mem_req), 32'(1));
      check("zw_hold", 32'(hold), 32'(0));
      check("zw_addr", 32'(mem_addr), 32'(0));
      tick();
      fetch = 1'b0; mem_ack = 1'b0;
      check("zw_instr", 32'(instr), 32'h5B);
      check("zw_pc", 32'(pc), 32'(1));
      run_dew("zw", 4'h5, 1'b1, 1'b1);
      check("zw_rd", 32'(rd), 32'(2));
      check("zw_rs", 32'(rs), 32'(3));
      check("zw_reg_we_off", 32'(reg_we), 32'(0));
      check("zw_pc_after_wb", 32'(pc), 32'(1));

      // Slow memory: ack on the fourth fetch cycle
      fetch = 1'b1; mem_rdata = 8'hA6;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("slow_hold", 32'(hold), 32'(1));
         check("slow_addr", 32'(mem_addr), 32'(1));
         check("slow_instr_kept", 32'(instr), 32'h5B);
         tick();
      end
      mem_ack = 1'b1;
      #1;
      check("slow_hold_ack", 32'(hold), 32'(0));
      tick();
      fetch = 1'b0; mem_ack = 1'b0;
      check("slow_instr", 32'(instr), 32'hA6);
      check("slow_pc", 32'(pc), 32'(2));
      run_dew("slow", 4'hA, 1'b1, 1'b1);

      // Timeout: fifteen stalled cycles, hold drops on the sixteenth
      fetch = 1'b1; mem_rdata = 8'hFF;
      for (int i = 0; i < 15; i++) begin
         #1;
         check("to_hold", 32'(hold), 32'(1));
         tick();
      end
      #1;
      check("to_hold_drop", 32'(hold), 32'(0));
      check("to_mem_req", 32'(mem_req), 32'(1));
      check("to_flag_pre", 32'(timeout), 32'(0));
      tick();
      fetch = 1'b0;
      check("to_flag", 32'(timeout), 32'(1));
      check("to_instr", 32'(instr), 32'h00);
      check("to_pc", 32'(pc), 32'(3));
      run_dew("to", 4'h0, 1'b0, 1'b0);

      // Walk PC from 3 up to 0xFF with NOP instructions
      for (int i = 0; i < 252; i++) quick_cycle(8'h00);
      check("wrap_pc_ff", 32'(pc), 32'hFF);

      // Wrap on fetch, then JMP to {rd,rs}=9
      fetch = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hE9;
      #1;
      check("wrap_addr", 32'(mem_addr), 32'hFF);
      tick();
      fetch = 1'b0; mem_ack = 1'b0;
      check("wrap_pc_00", 32'(pc), 32'h00);
      check("jmp_instr", 32'(instr), 32'hE9);
      run_dew("jmp", 4'hE, 1'b1, 1'b0);
      check("jmp_pc", 32'(pc), 32'h09);

      // Decode strobe while a fetch is expected
      decode = 1'b1;
      #1;
      check("seq_mem_req", 32'(mem_req), 32'(0));
      tick();
      decode = 1'b0;
      check("seq_err_set", 32'(seq_err), 32'(1));
      check("seq_opcode_kept", 32'(opcode), 32'hE);
      check("seq_rd_kept", 32'(rd), 32'(2));

      // Fetch and decode together
      fetch = 1'b1; decode = 1'b1; mem_ack = 1'b1;
      #1;
      check("dual_mem_req", 32'(mem_req), 32'(0));
      check("dual_hold", 32'(hold), 32'(0));
      tick();
      decode = 1'b0; mem_ack = 1'b0;
      check("dual_pc", 32'(pc), 32'h09);
      check("dual_seq_err", 32'(seq_err), 32'(1));

      // Reset in the middle of a stalled fetch, then a late ack
      #1;
      check("mid_mem_req", 32'(mem_req), 32'(1));
      check("mid_hold", 32'(hold), 32'(1));
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_hold", 32'(hold), 32'(0));
      check("mid_rst_mem_req", 32'(mem_req), 32'(0));
      tick();
      reset = 1'b1; fetch = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h77;
      tick();
      mem_ack = 1'b0;
      check("late_ack_pc", 32'(pc), 32'(0));
      check("late_ack_instr", 32'(instr), 32'(0));
      check("late_seq_err", 32'(seq_err), 32'(0));
      check("late_timeout", 32'(timeout), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
